uart_baud_gen_os: RTL and testbench

//  Oversampling UART baud generator with optional fractional divider. Emits an

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_baud_gen_os_if.sv | 29 ++
 rtl/uart_baud_prescaler.sv | 69 ++++++
 rtl/uart_baud_gen_os.sv | 114 +++++++++++
 tb/tb_uart_baud_gen_os.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART baud generator: default
// widths and the two-state run/idle enum used by the top-level FSM.
package uart_pkg;

    localparam int UART_CNT_W  = 16;
    localparam int UART_FRAC_W = 4;
    localparam int UART_OSR    = 16;

    typedef enum logic [0:0] {
        BAUD_IDLE = 1'b0,
        BAUD_RUN  = 1'b1
    } baud_state_e;

endpackage

// File: rtl/uart_baud_gen_os_if.sv
// Control/tick bundle between a UART engine (master) and the baud
// generator (slave). Signal names keep their direction suffixes as seen
// from the generator so both sides read the same names.
interface uart_baud_gen_os_if #(
    parameter int CNT_W  = 16,
    parameter int FRAC_W = 4,
    parameter int OSR_W  = 4
);

    logic              en_i;
    logic              restart_i;
    logic [CNT_W-1:0]  cfg_div_i;
    logic [FRAC_W-1:0] cfg_frac_i;
    logic              os_tick_o;
    logic              bit_tick_o;
    logic              mid_tick_o;
    logic [OSR_W-1:0]  os_idx_o;

    modport master (
        output en_i, restart_i, cfg_div_i, cfg_frac_i,
        input  os_tick_o, bit_tick_o, mid_tick_o, os_idx_o
    );

    modport slave (
        input  en_i, restart_i, cfg_div_i, cfg_frac_i,
        output os_tick_o, bit_tick_o, mid_tick_o, os_idx_o
    );

endinterface

// File: rtl/uart_baud_prescaler.sv
// Integer prescaler with optional fractional stretch. Counts 0..div+stretch
// while count_en is high and flags the terminal count combinationally on
// os_hit; the top registers it. Dropping count_en clears all state.
// Optional feature macro: UART_BAUD_FRAC_DIV_EN (fractional accumulator).
module uart_baud_prescaler #(
    parameter int CNT_W  = 16,
    parameter int FRAC_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              count_en,
    input  logic [CNT_W-1:0]  div,
    input  logic [FRAC_W-1:0] frac,
    output logic              os_hit
);

    logic [CNT_W:0] cnt_r;
    logic [CNT_W:0] lim_s;
    logic           stretch_s;

    // Limit may exceed div by one clock when the previous period carried.
    assign lim_s  = {1'b0, div} + {{CNT_W{1'b0}}, stretch_s};
    assign os_hit = count_en && (cnt_r == lim_s);

    // Prescaler counter: wraps at the limit, held at zero when not counting.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_r <= {(CNT_W+1){1'b0}};
        end else if (!count_en) begin
            cnt_r <= {(CNT_W+1){1'b0}};
        end else if (os_hit) begin
            cnt_r <= {(CNT_W+1){1'b0}};
        end else begin
            cnt_r <= cnt_r + (CNT_W+1)'(1);
        end
    end

`ifdef UART_BAUD_FRAC_DIV_EN
    logic [FRAC_W-1:0] acc_r;
    logic              stretch_r;
    logic [FRAC_W:0]   sum_s;

    assign sum_s     = {1'b0, acc_r} + {1'b0, frac};
    assign stretch_s = stretch_r;

    // Fractional accumulator: its carry lengthens the following os period.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_r     <= {FRAC_W{1'b0}};
            stretch_r <= 1'b0;
        end else if (!count_en) begin
            acc_r     <= {FRAC_W{1'b0}};
            stretch_r <= 1'b0;
        end else if (os_hit) begin
            acc_r     <= sum_s[FRAC_W-1:0];
            stretch_r <= sum_s[FRAC_W];
        end else begin
            acc_r     <= acc_r;
            stretch_r <= stretch_r;
        end
    end
`else
    logic unused_frac_s;

    assign stretch_s     = 1'b0;
    assign unused_frac_s = ^frac;
`endif

endmodule

// File: rtl/uart_baud_gen_os.sv
// Oversampling UART baud generator. Produces an os tick every div+1(+stretch)
// clocks, tracks the oversample index within a bit and flags the bit wrap
// and mid-bit sample point. Divisor settings are shadowed and only picked up
// while idle, on restart, or at a bit boundary so a bit never changes speed.
// Optional feature macro: UART_BAUD_FRAC_DIV_EN (fractional divisor).
module uart_baud_gen_os
    import uart_pkg::*;
#(
    parameter int CNT_W  = UART_CNT_W,
    parameter int FRAC_W = UART_FRAC_W,
    parameter int OSR    = UART_OSR
) (
    input  logic               clk_i,
    input  logic               rst_i,
    uart_baud_gen_os_if.slave  bus
);

    localparam int OSR_W = $clog2(OSR);

    baud_state_e       state_r;
    baud_state_e       state_s;
    logic              count_en_s;
    logic              os_hit_s;
    logic              last_idx_s;
    logic              mid_idx_s;
    logic [CNT_W-1:0]  div_r;
    logic [FRAC_W-1:0] frac_r;
    logic [OSR_W-1:0]  idx_r;
    logic              os_tick_r;
    logic              bit_tick_r;
    logic              mid_tick_r;

    // Only a running generator without a pending realign advances time.
    assign count_en_s = (state_r == BAUD_RUN) && bus.en_i && !bus.restart_i;
    assign last_idx_s = (idx_r == OSR_W'(OSR - 1));
    assign mid_idx_s  = (idx_r == OSR_W'(OSR / 2 - 1));

    uart_baud_prescaler #(
        .CNT_W  (CNT_W),
        .FRAC_W (FRAC_W)
    ) u_prescaler (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .count_en (count_en_s),
        .div      (div_r),
        .frac     (frac_r),
        .os_hit   (os_hit_s)
    );

    // State register for the idle/run FSM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= BAUD_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic: enable alone decides between idle and run.
    always_comb begin
        state_s = state_r;
        case (state_r)
            BAUD_IDLE: begin
                if (bus.en_i) state_s = BAUD_RUN;
                else          state_s = BAUD_IDLE;
            end
            BAUD_RUN: begin
                if (bus.en_i) state_s = BAUD_RUN;
                else          state_s = BAUD_IDLE;
            end
            default: state_s = BAUD_IDLE;
        endcase
    end

    // Shadow divisor: reloaded while not counting and at each bit boundary.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_r  <= {CNT_W{1'b0}};
            frac_r <= {FRAC_W{1'b0}};
        end else if (!count_en_s || (os_hit_s && last_idx_s)) begin
            div_r  <= bus.cfg_div_i;
            frac_r <= bus.cfg_frac_i;
        end else begin
            div_r  <= div_r;
            frac_r <= frac_r;
        end
    end

    // Oversample index and registered tick outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_r      <= {OSR_W{1'b0}};
            os_tick_r  <= 1'b0;
            bit_tick_r <= 1'b0;
            mid_tick_r <= 1'b0;
        end else if (!count_en_s) begin
            idx_r      <= {OSR_W{1'b0}};
            os_tick_r  <= 1'b0;
            bit_tick_r <= 1'b0;
            mid_tick_r <= 1'b0;
        end else begin
            idx_r      <= os_hit_s ? (idx_r + OSR_W'(1)) : idx_r;
            os_tick_r  <= os_hit_s;
            bit_tick_r <= os_hit_s && last_idx_s;
            mid_tick_r <= os_hit_s && mid_idx_s;
        end
    end

    assign bus.os_tick_o  = os_tick_r;
    assign bus.bit_tick_o = bit_tick_r;
    assign bus.mid_tick_o = mid_tick_r;
    assign bus.os_idx_o   = idx_r;

endmodule

// File: tb/tb_uart_baud_gen_os.sv
// Bench for uart_baud_gen_os. A schedule-based model (absolute tick times,
// running tick count, fractional remainder) predicts every output each cycle;
// event timings measured on the DUT are pinned against hand-computed values.
// Honours UART_BAUD_FRAC_DIV_EN for the fractional expectations.
module tb_uart_baud_gen_os;

    localparam int OSR      = 16;
    localparam int FRAC_ONE = 16;
`ifdef UART_BAUD_FRAC_DIV_EN
    localparam int EXP_FRAC_IV = 72;
`else
    localparam int EXP_FRAC_IV = 64;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_baud_gen_os_if #(.CNT_W(16), .FRAC_W(4), .OSR_W(4)) bif ();

    uart_baud_gen_os dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (updated at each active edge) --------
    int cyc       = 0;
    bit chk_on    = 1'b0;
    bit m_run     = 1'b0;
    int next_at   = 0;
    int ticks     = 0;
    int sh_div    = 0;
    int sh_frac   = 0;
    int acc       = 0;
    int start_cyc = 0;
    bit e_os      = 1'b0;
    bit e_bit     = 1'b0;
    bit e_mid     = 1'b0;
    int e_idx     = 0;

    // Model: next tick is scheduled at an absolute cycle number.
    always @(posedge clk) begin
        int st;
        cyc    = cyc + 1;
        chk_on = 1'b1;
        if (rst || !bif.en_i) begin
            m_run = 1'b0;
            e_os = 1'b0; e_bit = 1'b0; e_mid = 1'b0; e_idx = 0;
        end else if (!m_run || bif.restart_i) begin
            m_run     = 1'b1;
            e_os = 1'b0; e_bit = 1'b0; e_mid = 1'b0; e_idx = 0;
            sh_div    = int'(bif.cfg_div_i);
            sh_frac   = int'(bif.cfg_frac_i);
            acc       = 0;
            ticks     = 0;
            start_cyc = cyc;
            next_at   = cyc + sh_div + 1;
        end else begin
            e_os = 1'b0; e_bit = 1'b0; e_mid = 1'b0;
            if (cyc == next_at) begin
                ticks = ticks + 1;
                e_os  = 1'b1;
                e_idx = ticks % OSR;
                e_bit = (e_idx == 0);
                e_mid = (e_idx == OSR / 2);
                st    = 0;
`ifdef UART_BAUD_FRAC_DIV_EN
                acc = acc + sh_frac;
                if (acc >= FRAC_ONE) begin
                    acc = acc - FRAC_ONE;
                    st  = 1;
                end
`endif
                if (e_bit) begin
                    sh_div  = int'(bif.cfg_div_i);
                    sh_frac = int'(bif.cfg_frac_i);
                end
                next_at = cyc + sh_div + 1 + st;
            end
        end
    end

    // ---------------- checking, measurement and stimulus -----------------
    int total = 0;
    int bad   = 0;
    int d_first_os, d_first_os_idx, d_first_mid, d_first_bit, d_bit_iv, d_after_bit;
    int last_bit   = -1;
    bit want_after = 1'b0;
    int seen_start = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic compare_cycle();
        if (start_cyc != seen_start) begin
            seen_start = start_cyc;
            d_first_os = -1; d_first_os_idx = -1; d_first_mid = -1;
            d_first_bit = -1; d_bit_iv = -1; d_after_bit = -1;
            last_bit = -1; want_after = 1'b0;
        end
        check("os_tick",  32'(bif.os_tick_o),  32'(e_os));
        check("bit_tick", 32'(bif.bit_tick_o), 32'(e_bit));
        check("mid_tick", 32'(bif.mid_tick_o), 32'(e_mid));
        check("os_idx",   32'(bif.os_idx_o),   32'(e_idx));
        if (bif.os_tick_o === 1'b1) begin
            if (d_first_os < 0) begin
                d_first_os     = cyc - start_cyc;
                d_first_os_idx = int'(bif.os_idx_o);
            end
            if (want_after && bif.bit_tick_o !== 1'b1) begin
                d_after_bit = cyc - last_bit;
                want_after  = 1'b0;
            end
        end
        if (bif.mid_tick_o === 1'b1 && d_first_mid < 0) d_first_mid = cyc - start_cyc;
        if (bif.bit_tick_o === 1'b1) begin
            if (d_first_bit < 0) d_first_bit = cyc - start_cyc;
            if (last_bit >= 0)   d_bit_iv = cyc - last_bit;
            last_bit   = cyc;
            want_after = 1'b1;
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (chk_on) compare_cycle();
        end
    endtask

    task automatic start_gen(input int div, input int frac);
        bif.en_i       = 1'b0;
        step(1);
        bif.cfg_div_i  = 16'(div);
        bif.cfg_frac_i = 4'(frac);
        bif.en_i       = 1'b1;
    endtask

    initial begin
        bit found;
        bif.en_i       = 1'b0;
        bif.restart_i  = 1'b0;
        bif.cfg_div_i  = 16'd3;
        bif.cfg_frac_i = 4'd0;
        rst = 1'b1;
        step(3);
        check("reset_idx", 32'(bif.os_idx_o), 32'd0);
        rst = 1'b0;
        step(2);

        // div=3: ticks every 4, mid at 32, bit at 64 and every 64 after.
        start_gen(3, 0);
        step(140);
        check("t1_first_os",  32'(d_first_os),  32'd4);
        check("t1_first_mid", 32'(d_first_mid), 32'd32);
        check("t1_first_bit", 32'(d_first_bit), 32'd64);
        check("t1_bit_iv",    32'(d_bit_iv),    32'd64);

        // Realign at idx 5, then change div mid-bit to 7.
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(1);
            if (bif.os_idx_o == 4'd5) found = 1'b1;
        end
        check("wait_idx5", 32'(found), 32'd1);
        bif.restart_i = 1'b1;
        step(1);
        bif.restart_i = 1'b0;
        step(10);
        bif.cfg_div_i = 16'd7;
        step(90);
        check("t3_first_os",     32'(d_first_os),     32'd4);
        check("t3_first_os_idx", 32'(d_first_os_idx), 32'd1);
        check("t3_first_mid",    32'(d_first_mid),    32'd32);
        check("t4_first_bit",    32'(d_first_bit),    32'd64);
        check("t4_after_bit",    32'(d_after_bit),    32'd8);

        // Disable mid-bit, re-enable: full latency from idx 0.
        bif.en_i = 1'b0;
        step(3);
        bif.cfg_div_i = 16'd3;
        bif.en_i = 1'b1;
        step(40);
        check("t5_en_first_os",  32'(d_first_os),  32'd4);
        check("t5_en_first_mid", 32'(d_first_mid), 32'd32);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(12);
        check("t5_rst_first_os", 32'(d_first_os), 32'd4);

        // div=0: os tick every cycle, bit every 16.
        start_gen(0, 0);
        step(40);
        check("t6_first_os",  32'(d_first_os),  32'd1);
        check("t6_first_bit", 32'(d_first_bit), 32'd16);
        check("t6_bit_iv",    32'(d_bit_iv),    32'd16);

        // Fractional half-clock stretch.
        start_gen(3, 8);
        step(170);
        check("t2_first_os", 32'(d_first_os), 32'd4);
        check("t2_bit_iv",   32'(d_bit_iv),   32'(EXP_FRAC_IV));

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            rst           = ($urandom_range(0, 499) == 0);
            bif.en_i      = ($urandom_range(0, 99) != 0);
            bif.restart_i = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 36) == 0) begin
                bif.cfg_div_i  = 16'($urandom_range(0, 4));
                bif.cfg_frac_i = 4'($urandom_range(0, 15));
            end
            step(1);
        end
        rst           = 1'b0;
        bif.restart_i = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
